// File: rtl/text_screen_loader_if.sv
// Loader control, data-memory read and display-write signals bundled together.
// master = loader side; slave = the environment (CPU memory and display buffer).
interface text_screen_loader_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_valid;
    logic              disp_we;
    logic [9:0]        disp_addr;
    logic [7:0]        disp_data;

    modport master (
        input  start, mem_rdata, mem_valid,
        output busy, done, mem_rd, mem_addr, disp_we, disp_addr, disp_data
    );

    modport slave (
        output start, mem_rdata, mem_valid,
        input  busy, done, mem_rd, mem_addr, disp_we, disp_addr, disp_data
    );
endinterface

// File: rtl/text_screen_loader.sv
// Fills the 11x64 text buffer: label rows from ROM strings, data rows from memory.
// First write the cycle after start; each data byte waits in FETCH until mem_valid.
module text_screen_loader #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] CODED_BASE   = 'h0,
    parameter logic [ADDR_W-1:0] DECODED_BASE = 'h100
) (
    input  logic                 clk,
    input  logic                 reset,
    text_screen_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, LABEL, FETCH, WRITE, DONE} state_t;

    localparam logic [9:0]        LAST_P = 10'd703;
    localparam logic [17*8-1:0]   ROW0   = "Texto codificado:";
    localparam logic [23*8-1:0]   ROW6   = "Texto decodificado con:";

    state_t     state, state_nxt;
    logic [9:0] p, p_nxt;
    logic [7:0] dat, dat_nxt;

    function automatic logic in_label(input logic [9:0] a);
        return (a < 10'd64) || ((a >= 10'd320) && (a < 10'd448));
    endfunction

    // Row 5 (320..383) has no text, so it falls through to the blank default.
    function automatic logic [7:0] label_byte(input logic [9:0] a);
        logic [7:0] b;
        int         col;
        b = 8'h20;
        if (a < 10'd64) begin
            col = int'(a);
            if (col < 17) b = ROW0[8*(16-col) +: 8];
        end else if (a >= 10'd384) begin
            col = int'(a) - 384;
            if (col < 23) b = ROW6[8*(22-col) +: 8];
        end
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [9:0] a);
        if (a < 10'd320) return CODED_BASE + ADDR_W'(a - 10'd64);
        return DECODED_BASE + ADDR_W'(a - 10'd448);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            p     <= '0;
            dat   <= '0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            dat   <= dat_nxt;
        end
    end

    // Outputs depend only on state, p and dat; inputs only steer the next state.
    always_comb begin
        state_nxt     = state;
        p_nxt         = p;
        dat_nxt       = dat;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_addr  = '0;
        bus.disp_we   = 1'b0;
        bus.disp_addr = '0;
        bus.disp_data = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = in_label(p) ? LABEL : FETCH;
            end
            LABEL: begin
                bus.busy      = 1'b1;
                bus.disp_we   = 1'b1;
                bus.disp_addr = p;
                bus.disp_data = label_byte(p);
                p_nxt         = p + 10'd1;
                if (p == LAST_P)               state_nxt = DONE;
                else if (!in_label(p + 10'd1)) state_nxt = FETCH;
            end
            FETCH: begin
                bus.busy     = 1'b1;
                bus.mem_rd   = 1'b1;
                bus.mem_addr = fetch_addr(p);
                if (bus.mem_valid) begin
                    dat_nxt   = bus.mem_rdata;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.busy      = 1'b1;
                bus.disp_we   = 1'b1;
                bus.disp_addr = p;
                bus.disp_data = dat;
                p_nxt         = p + 10'd1;
                if (p == LAST_P)              state_nxt = DONE;
                else if (in_label(p + 10'd1)) state_nxt = LABEL;
                else                          state_nxt = FETCH;
            end
            DONE: begin
                bus.done  = 1'b1;
                p_nxt     = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_text_screen_loader.sv
// Drives loads against a bench-side memory with random latency and checks every
// display write against a row-map model of the screen contents.
module tb_text_screen_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    text_screen_loader_if #(.ADDR_W(32)) bus();

    text_screen_loader #(
        .ADDR_W(32), .CODED_BASE(32'h0), .DECODED_BASE(32'h100)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    string      row0_s = "Texto codificado:";
    string      row6_s = "Texto decodificado con:";
    logic [7:0] memimg [512];

    int n_cmp = 0, n_bad = 0;
    int exp_addr, hs_cnt, dat_writes, done_cnt, done_cyc, cyc;
    int delay_mode, cur_delay, wcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        if (a < 64)  return (a < 17) ? row0_s[a] : 8'h20;
        if (a < 320) return memimg[a - 64];
        if (a < 384) return 8'h20;
        if (a < 448) return (a - 384 < 23) ? row6_s[a - 384] : 8'h20;
        if (a < 704) return memimg[256 + a - 448];
        return 8'hxx;
    endfunction

    function automatic logic [31:0] exp_mem_addr(input int a);
        return (a < 320) ? 32'(a - 64) : 32'(32'h100 + a - 448);
    endfunction

    function automatic int pick_delay();
        return (delay_mode < 0) ? int'($urandom_range(0, 5)) : delay_mode;
    endfunction

    task automatic model_clear(input int mode);
        exp_addr = 0; hs_cnt = 0; dat_writes = 0; done_cnt = 0; done_cyc = 0;
        cyc = 0; wcnt = 0; delay_mode = mode; cur_delay = pick_delay();
    endtask

    // One clock: observe the DUT #1 after the edge, then play the memory side.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.disp_we === 1'b1) begin
            check("wr_addr", 32'(bus.disp_addr), 32'(exp_addr));
            check("wr_data", 32'(bus.disp_data), 32'(exp_byte(exp_addr)));
            if ((exp_addr >= 64 && exp_addr < 320) || exp_addr >= 448) begin
                dat_writes++;
                check("wr_after_valid", 32'(dat_writes), 32'(hs_cnt));
            end
            exp_addr++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.mem_rd === 1'b1)
            check("fetch_addr", bus.mem_addr, exp_mem_addr(exp_addr));

        if (bus.mem_valid) begin
            bus.mem_valid = 1'b0;
            bus.mem_rdata = 8'($urandom);
        end else if (bus.mem_rd === 1'b1) begin
            if (wcnt >= cur_delay) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = memimg[bus.mem_addr[8:0]];
                hs_cnt++;
                wcnt = 0;
                cur_delay = pick_delay();
            end else begin
                wcnt++;
            end
        end else if (delay_mode < 0 && bus.disp_we === 1'b1 && $urandom_range(0, 3) == 0) begin
            // Stray valid while writing must be ignored.
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 8'($urandom);
        end
    endtask

    task automatic run_load(input string tag, input int mode, input int want_cyc, input int poke_at);
        bit poked = 0;
        model_clear(mode);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check({tag, "_first_busy"}, 32'(bus.busy), 32'd1);
        while (done_cnt == 0 && cyc < 6000) begin
            if (poke_at >= 0 && !poked && exp_addr >= poke_at) begin
                bus.start = 1'b1;
                poked = 1;
            end
            cycle();
            bus.start = 1'b0;
            if (bus.done !== 1'b1) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        end
        check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_we"}, 32'(bus.disp_we), 32'd0);
        if (want_cyc > 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(want_cyc));
        check({tag, "_writes"}, 32'(exp_addr), 32'd704);
        repeat (5) cycle();
        check({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_single_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_no_extra_wr"}, 32'(exp_addr), 32'd704);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rd"}, 32'(bus.mem_rd), 32'd0);
        check({tag, "_maddr"}, bus.mem_addr, 32'd0);
        check({tag, "_we"}, 32'(bus.disp_we), 32'd0);
        check({tag, "_daddr"}, 32'(bus.disp_addr), 32'd0);
        check({tag, "_ddata"}, 32'(bus.disp_data), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 8'h00;
        model_clear(1);
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;
        repeat (2) cycle();
        check_quiet("idle");

        // Coded/decoded memory returns low address byte xor A5.
        for (int i = 0; i < 512; i++) memimg[i] = 8'(i) ^ 8'hA5;
        run_load("xor", 1, 1729, -1);

        // Random contents, random latency, start poked mid-load.
        for (int i = 0; i < 512; i++) memimg[i] = 8'($urandom);
        run_load("rand", -1, -1, 500);
        run_load("again", 1, 1729, -1);

        // Reset while fetching p=100 abandons the load.
        model_clear(3);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        while (!(bus.mem_rd === 1'b1 && exp_addr == 100) && cyc < 2000) cycle();
        check("reach_p100", 32'(exp_addr), 32'd100);
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        #1;
        check_quiet("rst_async");
        cycle();
        check_quiet("rst_next");
        reset = 1'b0;
        repeat (10) cycle();
        check_quiet("post_rst");
        run_load("fast", 0, 1217, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
